// File: rtl/error_matrix_sampler_pkg.sv
// Shared constants for the error-matrix sampler.
// Holds the matrix geometry per security level, the level encodings, the FSM state type
// and the CDF tables used by the sample stage.
package error_matrix_sampler_pkg;

    localparam int unsigned SampleInSize = 16;
    localparam int unsigned L5WidthQ     = 16;
    localparam int unsigned FrodoNbar    = 8;

    localparam int unsigned L1N = 640;
    localparam int unsigned L3N = 976;
    localparam int unsigned L5N = 1344;

    localparam int unsigned L1Total = L1N * FrodoNbar;  // 5120
    localparam int unsigned L3Total = L3N * FrodoNbar;  // 7808
    localparam int unsigned L5Total = L5N * FrodoNbar;  // 10752

    localparam logic [2:0] SecL1 = 3'd1;
    localparam logic [2:0] SecL3 = 3'd3;
    localparam logic [2:0] SecL5 = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Cumulative distribution tables; the last entry is never compared against.
    localparam int unsigned CdfL1Len = 13;
    localparam int unsigned CdfL3Len = 11;
    localparam int unsigned CdfL5Len = 7;

    localparam logic [14:0] CdfL1 [CdfL1Len] = '{
        15'd4643, 15'd13363, 15'd20579, 15'd25843, 15'd29227, 15'd31145, 15'd32103,
        15'd32525, 15'd32689, 15'd32745, 15'd32762, 15'd32766, 15'd32767
    };
    localparam logic [14:0] CdfL3 [CdfL3Len] = '{
        15'd5638, 15'd15915, 15'd23689, 15'd28571, 15'd31116, 15'd32217, 15'd32613,
        15'd32731, 15'd32760, 15'd32766, 15'd32767
    };
    localparam logic [14:0] CdfL5 [CdfL5Len] = '{
        15'd9142, 15'd23462, 15'd30338, 15'd32361, 15'd32725, 15'd32765, 15'd32767
    };

    // Unknown encodings fall back to L1.
    function automatic logic [2:0] norm_level(input logic [2:0] lvl);
        case (lvl)
            SecL3:   return SecL3;
            SecL5:   return SecL5;
            default: return SecL1;
        endcase
    endfunction

    function automatic int unsigned rows_for_level(input logic [2:0] lvl);
        case (norm_level(lvl))
            SecL3:   return L3N;
            SecL5:   return L5N;
            default: return L1N;
        endcase
    endfunction

endpackage

// File: rtl/error_matrix_sampler_sample.sv
// Combinational error sampler.
// Maps a 16-bit random value r to a signed error element: bit 0 is the sign, bits 15:1 are
// compared against the level's CDF table and the magnitude is the number of entries exceeded.
// Ports:
//   i_r          random input value
//   i_sec_level  security level (1/3/5, anything else treated as 1)
//   o_e_16       two's-complement error element
module sample
    import error_matrix_sampler_pkg::*;
(
    input  logic [SampleInSize-1:0] i_r,
    input  logic [2:0]              i_sec_level,
    output logic [L5WidthQ-1:0]     o_e_16
);

    logic [SampleInSize-2:0] t;
    logic [3:0]              mag_l1;
    logic [3:0]              mag_l3;
    logic [3:0]              mag_l5;
    logic [3:0]              mag;
    logic [L5WidthQ-1:0]     mag_ext;

    assign t = i_r[SampleInSize-1:1];

    always_comb begin
        mag_l1 = '0;
        mag_l3 = '0;
        mag_l5 = '0;
        for (int i = 0; i < CdfL1Len - 1; i++) begin
            mag_l1 = mag_l1 + {3'b000, (t > CdfL1[i])};
        end
        for (int i = 0; i < CdfL3Len - 1; i++) begin
            mag_l3 = mag_l3 + {3'b000, (t > CdfL3[i])};
        end
        for (int i = 0; i < CdfL5Len - 1; i++) begin
            mag_l5 = mag_l5 + {3'b000, (t > CdfL5[i])};
        end
        case (i_sec_level)
            SecL3:   mag = mag_l3;
            SecL5:   mag = mag_l5;
            default: mag = mag_l1;
        endcase
        mag_ext = {{(L5WidthQ - 4){1'b0}}, mag};
        o_e_16  = i_r[0] ? (-mag_ext) : mag_ext;
    end

endmodule

// File: rtl/error_matrix_sampler.sv
// Error-matrix sampler front end.
// Accepts 64-bit random words over valid/ready, splits each into four 16-bit lanes
// (lane 0 = bits 15:0 first), samples one lane per cycle and writes the resulting element to
// the error-matrix RAM in row-major order until n x NBAR elements are written.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        start request, honoured only when idle
//   i_sec_level    security level latched at start
//   i_valid/i_data input word stream; o_ready accepts a word
//   o_wr_en/o_wr_addr/o_wr_data  registered RAM write port
//   o_busy         high from the accepted start until the done pulse
//   o_done         one-cycle completion pulse, the cycle after the last write
module error_matrix_sampler
    import error_matrix_sampler_pkg::*;
#(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned NBAR   = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [2:0]          i_sec_level,
    input  logic                i_valid,
    input  logic [WORD_W-1:0]   i_data,
    output logic                o_ready,
    output logic                o_wr_en,
    output logic [ADDR_W-1:0]   o_wr_addr,
    output logic [L5WidthQ-1:0] o_wr_data,
    output logic                o_busy,
    output logic                o_done
);

    state_e                  state_q;
    logic [2:0]              level_q;
    logic [ADDR_W-1:0]       total_q;
    logic [ADDR_W-1:0]       cnt_q;
    logic [WORD_W-1:0]       buf_q;
    logic [1:0]              lane_q;
    logic                    full_q;

    logic                    last_elem;
    logic                    accept;
    logic [SampleInSize-1:0] lane_r;
    logic [L5WidthQ-1:0]     e_16;

    // cnt_q is the index of the element currently presented in lane_q.
    assign last_elem = (cnt_q == total_q - 1'b1);

    // Refill on the last lane keeps the stream bubble-free; no refill once the final word
    // has been taken.
    assign o_ready = (state_q == StRun) && (!full_q || ((lane_q == 2'd3) && !last_elem));
    assign accept  = i_valid && o_ready;

    always_comb begin
        unique case (lane_q)
            2'd0: lane_r = buf_q[0 +: SampleInSize];
            2'd1: lane_r = buf_q[SampleInSize +: SampleInSize];
            2'd2: lane_r = buf_q[2 * SampleInSize +: SampleInSize];
            2'd3: lane_r = buf_q[3 * SampleInSize +: SampleInSize];
            default: lane_r = '0;
        endcase
    end

    sample u_sample (
        .i_r         (lane_r),
        .i_sec_level (level_q),
        .o_e_16      (e_16)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            level_q   <= SecL1;
            total_q   <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            lane_q    <= '0;
            full_q    <= 1'b0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            o_done  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        level_q <= norm_level(i_sec_level);
                        total_q <= ADDR_W'(rows_for_level(i_sec_level) * NBAR);
                        cnt_q   <= '0;
                        lane_q  <= '0;
                        full_q  <= 1'b0;
                        o_busy  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (full_q) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= cnt_q;
                        o_wr_data <= e_16;
                        cnt_q     <= cnt_q + 1'b1;
                        if (last_elem) begin
                            full_q  <= 1'b0;
                            state_q <= StDone;
                        end else if (lane_q == 2'd3) begin
                            if (accept) begin
                                buf_q  <= i_data;
                                lane_q <= '0;
                            end else begin
                                full_q <= 1'b0;
                            end
                        end else begin
                            lane_q <= lane_q + 2'd1;
                        end
                    end else if (accept) begin
                        buf_q  <= i_data;
                        lane_q <= '0;
                        full_q <= 1'b1;
                    end
                end
                StDone: begin
                    // Last write is visible during this state; the pulse follows it.
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_error_matrix_sampler.sv
module tb_error_matrix_sampler;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned ADDR_W = 14;

    logic              clk;
    logic              i_rst;
    logic              i_start;
    logic [2:0]        i_sec_level;
    logic              i_valid;
    logic [63:0]       i_data;
    logic              o_ready;
    logic              o_wr_en;
    logic [13:0]       o_wr_addr;
    logic [15:0]       o_wr_data;
    logic              o_busy;
    logic              o_done;

    int checks = 0;
    int errors = 0;

    localparam int CdfL1[13] = '{4643, 13363, 20579, 25843, 29227, 31145, 32103, 32525, 32689,
                                 32745, 32762, 32766, 32767};
    localparam int CdfL3[11] = '{5638, 15915, 23689, 28571, 31116, 32217, 32613, 32731, 32760,
                                 32766, 32767};
    localparam int CdfL5[7]  = '{9142, 23462, 30338, 32361, 32725, 32765, 32767};

    error_matrix_sampler #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .NBAR   (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_sec_level (i_sec_level),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference sampler: magnitude = count of table entries below r/2 (last entry excluded),
    // negated when r is odd.
    function automatic logic [15:0] ref_sample(input logic [15:0] r, input logic [2:0] lvl);
        int t;
        int mag;
        t = int'(r) / 2;
        mag = 0;
        if (lvl == 3'd3) begin
            for (int i = 0; i < 10; i++) if (t > CdfL3[i]) mag++;
        end else if (lvl == 3'd5) begin
            for (int i = 0; i < 6; i++) if (t > CdfL5[i]) mag++;
        end else begin
            for (int i = 0; i < 12; i++) if (t > CdfL1[i]) mag++;
        end
        if (r[0]) mag = -mag;
        return 16'(mag);
    endfunction

    function automatic int ref_total(input logic [2:0] lvl);
        if (lvl == 3'd3) return 976 * 8;
        if (lvl == 3'd5) return 1344 * 8;
        return 640 * 8;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sampling run. Words are random; acceptance and element order are tracked by the
    // bench and every write, ready and busy value is compared against that account.
    task automatic do_run(input string name, input logic [2:0] lvl, input int valid_pct,
                          input bit extra_valid, input int abort_at, input int mid_start_at,
                          input bit first_fixed);
        logic [63:0] words[$];
        logic [15:0] exp_e[$];
        logic [15:0] first_e[4];
        int total, nwords, acc, w, cyc, budget, done_cnt, post, extra_acc, last_addr;
        int addr_bad, data_bad, ready_bad, busy_bad, done_bad, post_bad;
        bit prev_wr, exp_ready, exp_busy, v, finished;

        total = ref_total(lvl);
        nwords = total / 4;
        for (int j = 0; j < nwords; j++) begin
            logic [63:0] wd;
            wd = {$urandom(), $urandom()};
            if (first_fixed && j == 0) wd = 64'h0000_0002_0001_0000;
            words.push_back(wd);
            for (int k = 0; k < 4; k++) exp_e.push_back(ref_sample(wd[16*k +: 16], lvl));
        end
        for (int k = 0; k < 4; k++) first_e[k] = 16'hdead;
        acc = 0; w = 0; cyc = 0; done_cnt = 0; post = 0; extra_acc = 0; last_addr = -1;
        addr_bad = 0; data_bad = 0; ready_bad = 0; busy_bad = 0; done_bad = 0; post_bad = 0;
        prev_wr = 1'b0; finished = 1'b0;
        budget = 3 * total + 200;

        @(negedge clk);
        i_valid = 1'b0;
        i_start = 1'b1;
        i_sec_level = lvl;
        @(negedge clk);
        i_start = 1'b0;
        i_sec_level = 3'($urandom());

        while (!finished) begin
            if (o_wr_en) begin
                if (o_wr_addr !== 14'(w)) addr_bad++;
                if (w >= total || o_wr_data !== exp_e[w]) data_bad++;
                if (w < 4) first_e[w] = o_wr_data;
                last_addr = int'(o_wr_addr);
                w++;
            end
            if (o_done) begin
                done_cnt++;
                if (!prev_wr || w != total) done_bad++;
            end
            exp_busy = (done_cnt == 0);
            if (o_busy !== exp_busy) busy_bad++;
            exp_ready = (done_cnt == 0) && (4 * acc - w <= 1) && (acc < nwords);
            if (o_ready !== exp_ready) ready_bad++;

            if (abort_at >= 0 && w == abort_at + 1) begin
                i_rst = 1'b1;
                @(negedge clk);
                check({name, " reset outputs"},
                      {o_wr_en, o_done, o_busy, o_ready, o_wr_addr, o_wr_data}, 64'h0);
                i_rst = 1'b0;
                i_valid = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if (o_wr_en || o_done || o_busy || o_ready) post_bad++;
                end
                i_valid = 1'b0;
                check({name, " quiet after reset"}, post_bad, 0);
                check({name, " writes before reset"}, w, abort_at + 1);
                check({name, " addr before reset"}, addr_bad, 0);
                return;
            end

            i_start = (mid_start_at >= 0 && cyc == mid_start_at);
            if (acc < nwords) begin
                v = ($urandom_range(99) < valid_pct);
                i_data = words[acc];
            end else begin
                v = extra_valid;
                i_data = {$urandom(), $urandom()};
            end
            i_valid = v;
            if (v && o_ready) begin
                if (acc < nwords) acc++;
                else extra_acc++;
            end

            prev_wr = o_wr_en;
            if (done_cnt > 0) post++;
            if (post >= 5) finished = 1'b1;
            cyc++;
            if (cyc > budget) finished = 1'b1;
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_start = 1'b0;

        check({name, " write count"}, w, total);
        check({name, " addr sequence"}, addr_bad, 0);
        check({name, " data vs model"}, data_bad, 0);
        check({name, " ready timing"}, ready_bad, 0);
        check({name, " busy"}, busy_bad, 0);
        check({name, " done pulses"}, done_cnt, 1);
        check({name, " done timing"}, done_bad, 0);
        check({name, " last addr"}, last_addr, total - 1);
        if (extra_valid) check({name, " surplus accepted"}, extra_acc, 0);
        if (first_fixed) begin
            check({name, " lane order"}, {first_e[0], first_e[1], first_e[2], first_e[3]},
                  {ref_sample(16'h0000, lvl), ref_sample(16'h0001, lvl),
                   ref_sample(16'h0002, lvl), ref_sample(16'h0000, lvl)});
            check({name, " lane values"}, {first_e[0], first_e[1], first_e[2], first_e[3]},
                  64'h0);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        i_sec_level = 3'd0;
        i_valid = 1'b0;
        i_data = '0;
        repeat (3) @(negedge clk);
        check("reset wr_en/done/busy/ready", {o_wr_en, o_done, o_busy, o_ready}, 4'b0000);
        check("reset wr_addr", o_wr_addr, 0);
        check("reset wr_data", o_wr_data, 0);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle ready", o_ready, 1'b0);

        do_run("L1 full", 3'd1, 100, 1'b0, -1, -1, 1'b1);
        do_run("L3 gaps", 3'd3, 50, 1'b0, -1, -1, 1'b0);
        do_run("L5 boundary", 3'd5, 100, 1'b1, -1, -1, 1'b0);
        do_run("L1 abort", 3'd1, 90, 1'b0, 100, -1, 1'b0);
        do_run("L7 restart", 3'd7, 80, 1'b0, -1, 2000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
